// File: rtl/cpu_oci_trace_pkg.sv
// Shared types and constants for the OCI trace capture block.
package cpu_oci_trace_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2,
        DRAIN  = 2'd3
    } trace_state_t;

    localparam int DROP_W = 16;

    function automatic int entry_w(input int cnt_w, input int data_w);
        return cnt_w + data_w;
    endfunction

endpackage

// File: rtl/cpu_oci_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module cpu_oci_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Output register reset maps onto the block-RAM output-latch reset.
    always_ff @(posedge clk) begin
        if (i_rst)        r_q <= '0;
        else if (i_rd_en) r_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/cpu_oci_trace_capture.sv
// Circular pre/post-trigger trace capture of dct_buffer/dct_count with valid/ready drain.
module cpu_oci_trace_capture
    import cpu_oci_trace_pkg::*;
#(
    parameter int DATA_W     = 30,
    parameter int CNT_W      = 4,
    parameter int DEPTH      = 16,
    parameter int POST_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       dct_valid,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [CNT_W+DATA_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = entry_w(CNT_W, DATA_W);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

    trace_state_t      r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     r_post_rem;
    logic [DROP_W-1:0] r_drop;
    logic              r_rd_valid;

    logic          w_wr;
    logic          w_full;
    logic          w_ovw;
    logic          w_pop;
    logic          w_load;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [EW-1:0] w_wr_data;

    assign w_wr      = dct_valid && ((r_state == ARMED) || (r_state == POST));
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_ovw     = w_wr && w_full;
    assign w_pop     = (r_state == DRAIN) && r_rd_valid && rd_ready;
    // First fetch after entering DRAIN; afterwards rd_valid only falls when level hits 0.
    assign w_load    = (r_state == DRAIN) && !r_rd_valid && (r_level != '0);
    assign w_rd_en   = w_pop || w_load;
    assign w_rd_addr = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_wr_data = {dct_count, dct_buffer};

    cpu_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk       (clk),
        .i_rst     (reset),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARMED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_post_rem <= '0;
            r_drop     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr)           r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_ovw || w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_ovw)          r_drop   <= sat_inc(r_drop);

            if (w_wr && !w_full) r_level <= r_level + LW'(1);
            else if (w_pop)      r_level <= r_level - LW'(1);

            if (w_load)     r_rd_valid <= 1'b1;
            else if (w_pop) r_rd_valid <= (r_level != LW'(1));

            case (r_state)
                ARMED: begin
                    if (test_has_ended) begin
                        r_state <= FROZEN;
                    end else if (test_ending) begin
                        if (POST_WORDS == 0) begin
                            r_state <= FROZEN;
                        end else begin
                            r_state    <= POST;
                            r_post_rem <= LW'(POST_WORDS);
                        end
                    end
                end
                POST: begin
                    if (test_has_ended) begin
                        r_state <= FROZEN;
                    end else if (w_wr) begin
                        r_post_rem <= r_post_rem - LW'(1);
                        if (r_post_rem == LW'(1)) r_state <= FROZEN;
                    end
                end
                FROZEN:  r_state <= DRAIN;
                default: r_state <= DRAIN;
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign level    = r_level;
    assign drop_cnt = r_drop;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Directed scoreboard bench for cpu_oci_trace_capture (DEPTH=16, POST_WORDS=4).
module tb_cpu_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int POST_W = 4;
    localparam int EW     = CNT_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              dct_valid = 1'b0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [EW-1:0]     rd_data;
    logic [4:0]        level;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] sb [$];

    cpu_oci_trace_capture #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .POST_WORDS (POST_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .level          (level),
        .drop_cnt       (drop_cnt),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dct_valid = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    // One frame for one cycle; a stored frame is pushed, keeping at most DEPTH newest.
    task automatic send(input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] d,
                        input bit te, input bit the, input bit stored);
        dct_count = c; dct_buffer = d; dct_valid = 1'b1;
        test_ending = te; test_has_ended = the;
        if (stored) begin
            sb.push_back({c, d});
            if (sb.size() > DEPTH) void'(sb.pop_front());
        end
        tick();
        dct_valid = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    endtask

    task automatic pulse_end();
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1,1 repeating.
    task automatic drain(input int mode, input int max_pops);
        bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          cyc = 0;
        int          pops = 0;
        bit          stalled = 1'b0;
        bit          prev_hs = 1'b0;
        logic [EW-1:0] held = '0;
        while (sb.size() > 0 && pops < max_pops && cyc < 200) begin
            rd_ready = (mode == 0) ? 1'b1 : pat[cyc % 5];
            if (prev_hs) check("no_bubble", 64'(rd_valid), 64'd1);
            if (stalled) begin
                check("stall_valid", 64'(rd_valid), 64'd1);
                check("stall_data", 64'(rd_data), 64'(held));
            end
            prev_hs = 1'b0;
            stalled = 1'b0;
            if (rd_valid && rd_ready) begin
                check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
                pops++;
                prev_hs = (sb.size() > 0) && (mode == 0);
            end else if (rd_valid) begin
                held = rd_data;
                stalled = 1'b1;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        if (pops < max_pops) begin
            check("drain_left", 64'(sb.size()), 64'd0);
            check("drain_valid", 64'(rd_valid), 64'd0);
            check("drain_level", 64'(level), 64'd0);
            check("drain_state", 64'(state), 64'd3);
        end else begin
            check("partial_pops", 64'(pops), 64'(max_pops));
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_state", 64'(state), 64'd0);

        // Basic capture and drain
        for (int i = 1; i <= 5; i++) begin
            send(4'd1, 30'(i), 1'b0, 1'b0, 1'b1);
            check("basic_level", 64'(level), 64'(i));
        end
        pulse_end();
        check("basic_frozen", 64'(state), 64'd2);
        tick();
        check("basic_drain", 64'(state), 64'd3);
        check("basic_first_lat", 64'(rd_valid), 64'd0);
        drain(0, 100);
        check("basic_drop", 64'(drop_cnt), 64'd0);

        // Pre/post trigger split
        do_reset();
        for (int i = 0; i <= 8; i++) send(4'(i), 30'(i), 1'b0, 1'b0, 1'b1);
        send(4'd9, 30'd9, 1'b1, 1'b0, 1'b1);
        check("split_post", 64'(state), 64'd1);
        for (int i = 10; i <= 13; i++) send(4'(i), 30'(i), 1'b0, 1'b0, 1'b1);
        check("split_frozen", 64'(state), 64'd2);
        send(4'd14, 30'd14, 1'b0, 1'b0, 1'b0);
        check("split_level", 64'(level), 64'd14);
        send(4'd15, 30'd15, 1'b0, 1'b0, 1'b0);
        check("split_level2", 64'(level), 64'd14);
        drain(0, 100);

        // Overflow
        do_reset();
        for (int i = 0; i < 20; i++) send(4'(i), 30'(i), 1'b0, 1'b0, 1'b1);
        check("ovf_drop", 64'(drop_cnt), 64'd4);
        check("ovf_level", 64'(level), 64'd16);
        pulse_end();
        drain(0, 100);
        check("ovf_drop_after", 64'(drop_cnt), 64'd4);

        // Simultaneous trigger and end with a frame
        do_reset();
        send(4'd0, 30'hAA, 1'b1, 1'b1, 1'b1);
        check("sim_frozen", 64'(state), 64'd2);
        check("sim_level", 64'(level), 64'd1);
        send(4'd0, 30'hBB, 1'b1, 1'b0, 1'b0);
        check("sim_level2", 64'(level), 64'd1);
        drain(0, 100);

        // Backpressure
        do_reset();
        for (int i = 0; i < 3; i++) send(4'(i + 3), 30'(32'h100 + i), 1'b0, 1'b0, 1'b1);
        pulse_end();
        drain(1, 100);

        // Reset mid-drain
        do_reset();
        for (int i = 0; i < 8; i++) send(4'(i), 30'(32'h200 + i), 1'b0, 1'b0, 1'b1);
        pulse_end();
        drain(0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mid_valid", 64'(rd_valid), 64'd0);
        check("mid_data", 64'(rd_data), 64'd0);
        check("mid_level", 64'(level), 64'd0);
        check("mid_drop", 64'(drop_cnt), 64'd0);
        check("mid_state", 64'(state), 64'd0);
        for (int i = 0; i < 3; i++) send(4'(i + 7), 30'(32'h300 + i), 1'b0, 1'b0, 1'b1);
        check("mid_recapture", 64'(level), 64'd3);
        pulse_end();
        drain(0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
